bus_gen_arbiter: RTL and testbench
==================================

Name: bus_gen_arbiter

Overview:
- Multi-bus shared-bus model with a round-robin arbiter.
- Connects `drvrs` devices on each of `bits` independent buses.
- Per bus: pops one packet from a pending device, decodes the destination ID in the packet's top 8 bits, then pushes the packet to the destination device, or to all other devices on broadcast.
- Sits between the per-device FIFO drivers/monitors and forms the interconnect under verification.

Parameters:
- bits, 1, number of independent buses.
- drvrs, 4, devices per bus (2..255).
- pckg_sz, 32, packet width in bits (>=9); bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- broadcast, 8'hFF, destination ID meaning "all devices except source".

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  bits*drvrs  device has a packet at its FIFO head; index b*drvrs+d.
- D_pop  in  bits*drvrs*pckg_sz  head packet of each device; slice (b*drvrs+d)*pckg_sz +: pckg_sz.
- pop  out  bits*drvrs  one-cycle pop strobe to device FIFO.
- push  out  bits*drvrs  one-cycle push strobe into device receive side.
- D_push  out  bits*pckg_sz  packet being delivered on bus b; common to all devices of that bus.

Behaviour:
- Each bus b has its own FSM, round-robin pointer rr[b], packet register pkt[b] and source register src[b]. All outputs are registered.
- Reset (reset=0, asynchronous): pop=0, push=0, D_push=0, all FSMs in IDLE, rr=0, pkt=0, src=0.
- IDLE:
  - If any pndng of bus b is set, select the first set device searching rr[b], rr[b]+1, ... wrapping modulo drvrs.
  - Latch src=selected device and pkt=D_pop[selected]; go to POP.
  - With no pending device, stay in IDLE with all strobes 0.
- POP: pop[b][src]=1 for exactly this one cycle, then go to DEC.
- DEC: compute dest=pkt[pckg_sz-1 -: 8].
  - dest==broadcast: push mask = all devices except src.
  - dest<drvrs: push mask = one-hot dest. A self-addressed packet (dest==src) is delivered to src.
  - Otherwise: drop the packet with mask 0.
  - Next state is PUSH.
- PUSH:
  - push[b] = mask for one cycle; D_push[b] = pkt, held until the next PUSH.
  - Set rr[b]=(src+1) mod drvrs and return to IDLE.
  - A dropped packet still consumes the PUSH cycle with push=0.
- Throughput: 4 cycles per packet per bus, IDLE->POP->DEC->PUSH. Grant to pop latency is 1 cycle after the sampling edge.
- Buses operate fully independently and may push in the same cycle.
- pndng deasserting after a grant does not abort the transfer; the packet latched in IDLE is used.
- The bus never stalls on the receive side: devices must accept every push.
- Reset asserted mid-transfer: the packet in flight is lost and all outputs go to 0 immediately.
- Fairness: a device that is continuously pending is served at least once every drvrs transfers.

Optional Feature:
- Macro BUS_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, width bits*16.
  - Per-bus saturating count of packets dropped for invalid destination.
  - Increments in PUSH when mask==0 because of an invalid ID; saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: no port and no counter logic; dropped packets are discarded silently.

Test Plan (bits=1, drvrs=4, pckg_sz=32, broadcast=8'hFF, reset low for 50 ns, 10 ns clock):
- Reset: hold reset=0 with pndng=4'hF.
  - Required: pop=0, push=0, D_push=0 throughout.
  - After release, the first pop is pop[0].
- Normal: device 1 pending with D_pop[1]=32'h02_00ABCD.
  - Required: pop=4'b0010 for 1 cycle, then push=4'b0100 with D_push=32'h0200ABCD 2 cycles later.
- All-to-one: devices 0,1,3 pending, each with dest ID 8'h02.
  - Required: pops in order 0,1,3 at 4-cycle spacing.
  - Required: three pushes on push[2], each carrying the matching packet.
- One-to-all: device 0 sends 3 packets with dest IDs 1,2,3.
  - Required: push=4'b0010, 4'b0100, 4'b1000 in sequence.
- Broadcast: device 2 sends 32'hFF_123456.
  - Required: push=4'b1011 in one cycle with D_push=32'hFF123456.
- Invalid ID: device 3 sends dest 8'h07.
  - Required: pop[3] pulses, push stays 0.
  - Required: with BUS_DROP_CNT_EN, drop_cnt goes 0 -> 1.

Source files
------------

// File: rtl/bus_gen_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_gen_arbiter_if
// Bundles the device-side signals of the shared-bus model for every bus.
// Flat vectors are indexed by bus b and device d as b*drvrs+d.
//   pndng   : device has a packet waiting at its FIFO head
//   D_pop   : head packet of each device, slice (b*drvrs+d)*pckg_sz +: pckg_sz
//   pop     : one-cycle pop strobe back to the device FIFO
//   push    : one-cycle push strobe into the device receive side
//   D_push  : packet delivered on bus b, shared by all devices of that bus
// Modports: master = arbiter side, slave = device/driver side.
// ---------------------------------------------------------------------------
interface bus_gen_arbiter_if #(
  parameter int bits    = 1,
  parameter int drvrs   = 4,
  parameter int pckg_sz = 32
);
  logic [bits*drvrs-1:0]         pndng;
  logic [bits*drvrs*pckg_sz-1:0] D_pop;
  logic [bits*drvrs-1:0]         pop;
  logic [bits*drvrs-1:0]         push;
  logic [bits*pckg_sz-1:0]       D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bus_gen_arbiter.sv
// ---------------------------------------------------------------------------
// bus_gen_arbiter
// Shared-bus interconnect: `bits` independent buses, each serving `drvrs`
// devices through a round-robin arbiter. Each bus pops one packet from a
// pending device, decodes the destination ID held in the packet's top byte
// and pushes the packet to that device, or to every other device when the
// ID equals `broadcast`. IDs at or above drvrs (other than broadcast) are
// dropped. One packet per bus every four cycles: IDLE -> POP -> DEC -> PUSH.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : bus_gen_arbiter_if.master (pndng, D_pop, pop, push, D_push)
//   drop_cnt : (only with BUS_DROP_CNT_EN) per-bus saturating 16-bit count
//              of packets dropped for an invalid destination ID
// Optional feature macro: BUS_DROP_CNT_EN
// ---------------------------------------------------------------------------
module bus_gen_arbiter #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
`ifdef BUS_DROP_CNT_EN
  output logic [bits*16-1:0]  drop_cnt,
`endif
  bus_gen_arbiter_if.master   bus
);

  localparam int                IDX_W    = $clog2(drvrs);
  localparam logic [IDX_W:0]    DRVRS_W  = (IDX_W+1)'(drvrs);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(drvrs - 1);
  localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
  localparam logic [7:0]        DRVRS_8  = 8'(drvrs);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_DEC  = 2'd2,
    ST_PUSH = 2'd3
  } state_t;

  state_t                        state_r [bits];
  state_t                        state_s [bits];
  logic [IDX_W-1:0]              rr_r    [bits];
  logic [IDX_W-1:0]              rr_s    [bits];
  logic [IDX_W-1:0]              src_r   [bits];
  logic [IDX_W-1:0]              src_s   [bits];
  logic [pckg_sz-1:0]            pkt_r   [bits];
  logic [pckg_sz-1:0]            pkt_s   [bits];
  logic [bits-1:0][drvrs-1:0]    pop_r,   pop_s;
  logic [bits-1:0][drvrs-1:0]    push_r,  push_s;
  logic [bits-1:0][pckg_sz-1:0]  dpush_r, dpush_s;
  logic [drvrs-1:0]              pnd_s   [bits];
  logic [pckg_sz-1:0]            dpop_s  [bits][drvrs];
  logic [IDX_W:0]                pick_s;
  logic [7:0]                    dest_s;
`ifdef BUS_DROP_CNT_EN
  logic                          drop_r  [bits];
  logic                          drop_s  [bits];
  logic [bits-1:0][15:0]         cnt_r,   cnt_s;
`endif

  // Round-robin search starting at `start`; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [drvrs-1:0] pend,
                                             input logic [IDX_W-1:0] start);
    logic           found;
    logic [IDX_W:0] idx;
    logic [IDX_W-1:0] sel;
    found = 1'b0;
    sel   = {IDX_W{1'b0}};
    for (int k = 0; k < drvrs; k++) begin
      idx = {1'b0, start} + (IDX_W+1)'(k);
      if (idx >= DRVRS_W) idx = idx - DRVRS_W;
      if (!found && pend[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDX_W-1:0];
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [drvrs-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(drvrs-1){1'b0}}, 1'b1} << i;
  endfunction

  // Split the flat interface vectors into per-bus/per-device views.
  always_comb begin
    for (int b = 0; b < bits; b++) begin
      pnd_s[b] = bus.pndng[b*drvrs +: drvrs];
      for (int d = 0; d < drvrs; d++) begin
        dpop_s[b][d] = bus.D_pop[(b*drvrs+d)*pckg_sz +: pckg_sz];
      end
    end
  end

  // Per-bus next-state and next-output logic.
  always_comb begin
    pick_s  = {(IDX_W+1){1'b0}};
    dest_s  = 8'h00;
    pop_s   = {(bits*drvrs){1'b0}};
    push_s  = {(bits*drvrs){1'b0}};
    dpush_s = dpush_r;
`ifdef BUS_DROP_CNT_EN
    cnt_s   = cnt_r;
`endif
    for (int b = 0; b < bits; b++) begin
      state_s[b] = state_r[b];
      rr_s[b]    = rr_r[b];
      src_s[b]   = src_r[b];
      pkt_s[b]   = pkt_r[b];
`ifdef BUS_DROP_CNT_EN
      drop_s[b]  = drop_r[b];
`endif
      case (state_r[b])
        ST_IDLE: begin
          pick_s = rr_pick(pnd_s[b], rr_r[b]);
          if (pick_s[IDX_W]) begin
            // Packet is latched here so a later pndng drop cannot abort it.
            src_s[b]   = pick_s[IDX_W-1:0];
            pkt_s[b]   = dpop_s[b][pick_s[IDX_W-1:0]];
            pop_s[b]   = onehot(pick_s[IDX_W-1:0]);
            state_s[b] = ST_POP;
          end else begin
            state_s[b] = ST_IDLE;
          end
        end
        ST_POP: begin
          state_s[b] = ST_DEC;
        end
        ST_DEC: begin
          dest_s     = pkt_r[b][pckg_sz-1 -: 8];
          dpush_s[b] = pkt_r[b];
`ifdef BUS_DROP_CNT_EN
          drop_s[b]  = 1'b0;
`endif
          if (dest_s == broadcast) begin
            push_s[b] = ~onehot(src_r[b]);
          end else if (dest_s < DRVRS_8) begin
            // Self-addressed packets are delivered back to the source.
            push_s[b] = onehot(dest_s[IDX_W-1:0]);
          end else begin
            push_s[b] = {drvrs{1'b0}};
`ifdef BUS_DROP_CNT_EN
            drop_s[b] = 1'b1;
`endif
          end
          state_s[b] = ST_PUSH;
        end
        ST_PUSH: begin
          rr_s[b]    = (src_r[b] == LAST_IDX) ? {IDX_W{1'b0}} : src_r[b] + ONE_IDX;
`ifdef BUS_DROP_CNT_EN
          if (drop_r[b] && (cnt_r[b] != 16'hFFFF)) begin
            cnt_s[b] = cnt_r[b] + 16'd1;
          end else begin
            cnt_s[b] = cnt_r[b];
          end
          drop_s[b]  = 1'b0;
`endif
          state_s[b] = ST_IDLE;
        end
        default: begin
          state_s[b] = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset discards any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_r   <= {(bits*drvrs){1'b0}};
      push_r  <= {(bits*drvrs){1'b0}};
      dpush_r <= {(bits*pckg_sz){1'b0}};
`ifdef BUS_DROP_CNT_EN
      cnt_r   <= {(bits*16){1'b0}};
`endif
      for (int b = 0; b < bits; b++) begin
        state_r[b] <= ST_IDLE;
        rr_r[b]    <= {IDX_W{1'b0}};
        src_r[b]   <= {IDX_W{1'b0}};
        pkt_r[b]   <= {pckg_sz{1'b0}};
`ifdef BUS_DROP_CNT_EN
        drop_r[b]  <= 1'b0;
`endif
      end
    end else begin
      pop_r   <= pop_s;
      push_r  <= push_s;
      dpush_r <= dpush_s;
`ifdef BUS_DROP_CNT_EN
      cnt_r   <= cnt_s;
`endif
      for (int b = 0; b < bits; b++) begin
        state_r[b] <= state_s[b];
        rr_r[b]    <= rr_s[b];
        src_r[b]   <= src_s[b];
        pkt_r[b]   <= pkt_s[b];
`ifdef BUS_DROP_CNT_EN
        drop_r[b]  <= drop_s[b];
`endif
      end
    end
  end

  assign bus.pop    = pop_r;
  assign bus.push   = push_r;
  assign bus.D_push = dpush_r;
`ifdef BUS_DROP_CNT_EN
  assign drop_cnt   = cnt_r;
`endif

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_gen_arbiter
// Directed bench for bus_gen_arbiter with bits=1, drvrs=4, pckg_sz=32,
// broadcast=8'hFF. Outputs are sampled on the falling clock edge; inputs
// are driven there as well. Honours BUS_DROP_CNT_EN when defined.
// ---------------------------------------------------------------------------
module tb_bus_gen_arbiter;
  localparam int BITS  = 1;
  localparam int DRVRS = 4;
  localparam int PSZ   = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
`ifdef BUS_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  bus_gen_arbiter_if #(.bits(BITS), .drvrs(DRVRS), .pckg_sz(PSZ)) bus ();

  bus_gen_arbiter #(
    .bits(BITS), .drvrs(DRVRS), .pckg_sz(PSZ), .broadcast(8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef BUS_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pkt(input int d, input logic [31:0] v);
    bus.D_pop[d*PSZ +: PSZ] = v;
  endtask

  // One full transfer: pop within one cycle, one-cycle pop pulse,
  // push two cycles after the pop, one-cycle push pulse.
  task automatic xfer(input string tag, input logic [3:0] clr, input logic [3:0] exp_pop,
                      input logic [3:0] exp_push, input logic [31:0] exp_data);
    int gap;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gap++;
      if (bus.pop != 4'b0000) break;
    end
    check({tag, "_pop"}, 32'(bus.pop), 32'(exp_pop));
    check({tag, "_gap"}, 32'(gap), 32'd1);
    bus.pndng = bus.pndng & ~clr;
    @(negedge clk);
    check({tag, "_pop_end"}, 32'(bus.pop), 32'd0);
    @(negedge clk);
    check({tag, "_push"}, 32'(bus.push), 32'(exp_push));
    check({tag, "_dpush"}, bus.D_push, exp_data);
    @(negedge clk);
    check({tag, "_push_end"}, 32'(bus.push), 32'd0);
  endtask

  initial begin
    // Reset held with every device pending
    bus.pndng = 4'hF;
    set_pkt(0, 32'h00C0FFEE);
    set_pkt(1, 32'h00000000);
    set_pkt(2, 32'h00000000);
    set_pkt(3, 32'h00000000);
    repeat (4) begin
      @(negedge clk);
      check("rst_pop", 32'(bus.pop), 32'd0);
      check("rst_push", 32'(bus.push), 32'd0);
      check("rst_dpush", bus.D_push, 32'd0);
    end
`ifdef BUS_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    xfer("rst_first", 4'hF, 4'b0001, 4'b0001, 32'h00C0FFEE);

    // Normal unicast from device 1 to device 2
    set_pkt(1, 32'h0200ABCD);
    bus.pndng = 4'b0010;
    xfer("normal", 4'b0010, 4'b0010, 4'b0100, 32'h0200ABCD);

    // Reset asserted during a transfer clears outputs at once
    set_pkt(2, 32'h01000000);
    bus.pndng = 4'b0100;
    @(negedge clk);
    check("mid_pop", 32'(bus.pop), 32'(4'b0100));
    reset = 1'b0;
    bus.pndng = 4'b0000;
    #1;
    check("mid_rst_pop", 32'(bus.pop), 32'd0);
    check("mid_rst_push", 32'(bus.push), 32'd0);
    check("mid_rst_dpush", bus.D_push, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_idle_pop", 32'(bus.pop), 32'd0);
    check("mid_idle_push", 32'(bus.push), 32'd0);

    // All-to-one: devices 0,1,3 to device 2, served in order 0,1,3
    set_pkt(0, 32'h020000A0);
    set_pkt(1, 32'h020000A1);
    set_pkt(3, 32'h020000A3);
    bus.pndng = 4'b1011;
    xfer("a2o_0", 4'b0001, 4'b0001, 4'b0100, 32'h020000A0);
    xfer("a2o_1", 4'b0010, 4'b0010, 4'b0100, 32'h020000A1);
    xfer("a2o_3", 4'b1000, 4'b1000, 4'b0100, 32'h020000A3);

    // One-to-all: device 0 sends to 1, 2, 3
    set_pkt(0, 32'h01000001);
    bus.pndng = 4'b0001;
    xfer("o2a_1", 4'b0001, 4'b0001, 4'b0010, 32'h01000001);
    set_pkt(0, 32'h02000002);
    bus.pndng = 4'b0001;
    xfer("o2a_2", 4'b0001, 4'b0001, 4'b0100, 32'h02000002);
    set_pkt(0, 32'h03000003);
    bus.pndng = 4'b0001;
    xfer("o2a_3", 4'b0001, 4'b0001, 4'b1000, 32'h03000003);

    // Broadcast from device 2 reaches everyone but device 2
    set_pkt(2, 32'hFF123456);
    bus.pndng = 4'b0100;
    xfer("bcast", 4'b0100, 4'b0100, 4'b1011, 32'hFF123456);

    // Self-addressed packet returns to its source
    set_pkt(1, 32'h01000055);
    bus.pndng = 4'b0010;
    xfer("self", 4'b0010, 4'b0010, 4'b0010, 32'h01000055);

    // Invalid destination ID is popped and dropped
`ifdef BUS_DROP_CNT_EN
    check("drop_cnt_before", 32'(drop_cnt), 32'd0);
`endif
    set_pkt(3, 32'h07000077);
    bus.pndng = 4'b1000;
    xfer("invalid", 4'b1000, 4'b1000, 4'b0000, 32'h07000077);
`ifdef BUS_DROP_CNT_EN
    check("drop_cnt_after", 32'(drop_cnt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
